// File: rtl/uart_cmd_ctrl.sv
// Purpose: turns W/R/L byte packets from the UART into single-cycle RAM strobes and LED register updates.
// Latency: ram_we and cmd_done 1 cycle after the W data byte; ram_re 1 cycle after the R address byte,
//          with LEDs updated 3 cycles after it; an L data byte reaches the LEDs on the next cycle.
// Backpressure: rx_hold is high while a read is in flight. A byte that arrives then is dropped and counted as an error.
// Ports:
//   CLK, reset (synchronous, active-high)
//   rx_data/rx_valid/rx_error  receiver byte stream and framing-error pulse
//   rx_hold                    receiver flow control
//   ram_addr/ram_wdata/ram_we/ram_re/ram_rdata   RAM port; read data returns 1 cycle after ram_re
//   leds                       LED register (active-high)
//   cmd_done                   completion pulse
//   err_count                  saturating protocol error count
module uart_cmd_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 12000000
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              rx_error,
   output logic              rx_hold,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [7:0]        ram_rdata,
   output logic [7:0]        leds,
   output logic              cmd_done,
   output logic [7:0]        err_count
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_W_ADDR  = 3'd1;
   localparam logic [2:0] S_W_DATA  = 3'd2;
   localparam logic [2:0] S_R_ADDR  = 3'd3;
   localparam logic [2:0] S_L_DATA  = 3'd4;
   localparam logic [2:0] S_R_ISSUE = 3'd5;
   localparam logic [2:0] S_R_WAIT  = 3'd6;

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CMD_L = 8'h4C;

   // The timer only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
   localparam int              TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int              TMAX_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [TW-1:0]   TMAX   = TMAX_I[TW-1:0];

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic          ram_we_q;
   logic          ram_re_q;
   logic          in_pkt;
   logic          timed_out;
   logic          bad_cmd;
   logic          err_evt;

   assign rx_hold = (state == S_R_ISSUE) || (state == S_R_WAIT);
   assign in_pkt  = (state == S_W_ADDR) || (state == S_W_DATA) ||
                    (state == S_R_ADDR) || (state == S_L_DATA);

   // A byte arriving on the final allowed cycle still wins over the timeout.
   assign timed_out = (TIMEOUT != 0) && in_pkt && !rx_valid && !rx_error && (timer == TMAX);

   assign bad_cmd = (state == S_IDLE) && rx_valid &&
                    (rx_data != CMD_W) && (rx_data != CMD_R) && (rx_data != CMD_L);

   // All error sources merge into a single increment per cycle.
   assign err_evt = rx_error || (rx_valid && rx_hold) || bad_cmd || timed_out;

   // Strobes are masked while reset is high, so a write queued just before reset never reaches the RAM.
   assign ram_we = ram_we_q && !reset;
   assign ram_re = ram_re_q && !reset;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state     <= S_IDLE;
         timer     <= '0;
         leds      <= 8'h01;
         ram_addr  <= '0;
         ram_wdata <= 8'h00;
         ram_we_q  <= 1'b0;
         ram_re_q  <= 1'b0;
         cmd_done  <= 1'b0;
         err_count <= 8'h00;
      end else begin
         ram_we_q <= 1'b0;
         ram_re_q <= 1'b0;
         cmd_done <= 1'b0;

         if (err_evt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end

         // Any byte inside a packet restarts the inter-byte timer, as does leaving the packet states.
         if (!in_pkt || rx_valid || rx_error || timed_out || (TIMEOUT == 0)) begin
            timer <= '0;
         end else begin
            timer <= timer + TW'(1);
         end

         if (rx_error || timed_out) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (rx_valid) begin
                     case (rx_data)
                        CMD_W:   state <= S_W_ADDR;
                        CMD_R:   state <= S_R_ADDR;
                        CMD_L:   state <= S_L_DATA;
                        default: state <= S_IDLE;
                     endcase
                  end
               end
               S_W_ADDR: begin
                  if (rx_valid) begin
                     ram_addr <= rx_data[ADDR_W-1:0];
                     state    <= S_W_DATA;
                  end
               end
               S_W_DATA: begin
                  if (rx_valid) begin
                     ram_wdata <= rx_data;
                     ram_we_q  <= 1'b1;
                     cmd_done  <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
               S_R_ADDR: begin
                  if (rx_valid) begin
                     ram_addr <= rx_data[ADDR_W-1:0];
                     ram_re_q <= 1'b1;
                     state    <= S_R_ISSUE;
                  end
               end
               S_L_DATA: begin
                  if (rx_valid) begin
                     leds     <= rx_data;
                     cmd_done <= 1'b1;
                     state    <= S_IDLE;
                  end
               end
               S_R_ISSUE: begin
                  // ram_re is high this cycle. Completion is flagged in the cycle the data returns.
                  cmd_done <= 1'b1;
                  state    <= S_R_WAIT;
               end
               S_R_WAIT: begin
                  leds  <= ram_rdata;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: fixed vector table, hand-written corner sequences, then random traffic
// compared cycle by cycle against a packet-level reference model.
module tb_uart_cmd_ctrl;

   localparam int TMO = 100;

   logic       CLK;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic       rx_hold;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdata;
   logic       ram_we;
   logic       ram_re;
   logic [7:0] ram_rdata;
   logic [7:0] leds;
   logic       cmd_done;
   logic [7:0] err_count;

   uart_cmd_ctrl #(.ADDR_W(8), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .rx_hold(rx_hold),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
      .ram_rdata(ram_rdata), .leds(leds), .cmd_done(cmd_done), .err_count(err_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] init_val(input int i);
      init_val = 8'((i * 37 + 11) & 255);
   endfunction

   // Synchronous RAM with 1-cycle read latency
   logic [7:0] ram [256];
   bit         ram_init_done;
   always @(posedge CLK) begin
      if (!ram_init_done) begin
         for (int i = 0; i < 256; i++) ram[i] = init_val(i);
         ram_init_done <= 1'b1;
      end else begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         if (ram_re) ram_rdata <= ram[ram_addr];
      end
   end

   int n_vec = 0;
   int n_bad = 0;
   int cyc_n = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%02h exp=%02h", nm, cyc_n, act, exp);
      end
   endtask

   // Sampled outputs of the current cycle
   logic       s_we, s_re, s_done, s_hold;
   logic [7:0] s_leds, s_err, s_addr, s_wdata;

   // Reference model: packet bytes collected so far, plus the timing of an in-flight read
   logic [7:0] mq[$];
   int         quiet;
   int         rd_at;
   logic [7:0] rd_addr;
   logic [7:0] m_mem [256];
   logic       m_ok;
   logic       x_we, x_re, x_done;
   logic [7:0] x_leds, x_err, x_addr, x_wdata;

   task automatic model_step(input logic rst, input logic v, input logic e, input logic [7:0] d);
      logic hold, bump, nwe, nre, ndone;
      hold = (rd_at >= 0) && ((cyc_n == rd_at + 1) || (cyc_n == rd_at + 2));
      if (m_ok) begin
         chk("rx_hold", 8'(s_hold), 8'(hold));
         chk("ram_we", 8'(s_we), 8'(x_we && !rst));
         chk("ram_re", 8'(s_re), 8'(x_re && !rst));
         chk("cmd_done", 8'(s_done), 8'(x_done));
         chk("leds", s_leds, x_leds);
         chk("err_count", s_err, x_err);
         if (x_we && !rst) begin
            chk("ram_addr_w", s_addr, x_addr);
            chk("ram_wdata", s_wdata, x_wdata);
            m_mem[x_addr] = x_wdata;
         end
         if (x_re && !rst) chk("ram_addr_r", s_addr, x_addr);
      end
      nwe = 0; nre = 0; ndone = 0; bump = 0;
      if (rst) begin
         mq.delete();
         rd_at = -1; quiet = 0;
         x_leds = 8'h01; x_addr = 8'h00; x_wdata = 8'h00; x_err = 8'h00;
         m_ok = 1'b1;
      end else begin
         if (e) begin
            bump = 1;
            mq.delete();
            rd_at = -1;
         end else begin
            if (v && hold) begin
               bump = 1;
            end else if (v) begin
               quiet = 0;
               if (mq.size() == 0 && !(d inside {8'h57, 8'h52, 8'h4C})) begin
                  bump = 1;
               end else begin
                  mq.push_back(d);
                  if (mq[0] == 8'h57 && mq.size() == 2) begin
                     x_addr = d;
                  end else if (mq[0] == 8'h57 && mq.size() == 3) begin
                     x_wdata = d; nwe = 1; ndone = 1; mq.delete();
                  end else if (mq[0] == 8'h52 && mq.size() == 2) begin
                     x_addr = d; nre = 1; rd_addr = d; rd_at = cyc_n; mq.delete();
                  end else if (mq[0] == 8'h4C && mq.size() == 2) begin
                     x_leds = d; ndone = 1; mq.delete();
                  end
               end
            end else if (mq.size() > 0) begin
               quiet++;
               if (quiet == TMO) begin
                  bump = 1;
                  mq.delete();
               end
            end
            if (rd_at >= 0 && cyc_n == rd_at + 1) ndone = 1;
            if (rd_at >= 0 && cyc_n == rd_at + 2) begin
               x_leds = m_mem[rd_addr];
               rd_at = -1;
            end
         end
         if (bump && x_err != 8'hFF) x_err = x_err + 8'd1;
      end
      x_we = nwe; x_re = nre; x_done = ndone;
      cyc_n++;
   endtask

   // One clock cycle: drive inputs, observe this cycle's outputs, advance the model
   task automatic cyc(input logic rst, input logic v, input logic e, input logic [7:0] d);
      @(negedge CLK);
      reset = rst; rx_valid = v; rx_error = e; rx_data = d;
      #1;
      s_we = ram_we; s_re = ram_re; s_done = cmd_done; s_hold = rx_hold;
      s_leds = leds; s_err = err_count; s_addr = ram_addr; s_wdata = ram_wdata;
      model_step(rst, v, e, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b0, 1'b1, 1'b0, b);
   endtask

   typedef struct {
      logic       rst, v, e;
      logic [7:0] d;
      logic       we, re, done, hold;
      logic [7:0] leds, err;
   } vec_t;

   vec_t tbl[15];

   initial begin
      reset = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
      m_ok = 1'b0; rd_at = -1; quiet = 0; rd_addr = 8'h00;
      x_we = 0; x_re = 0; x_done = 0;
      x_leds = 8'h01; x_err = 8'h00; x_addr = 8'h00; x_wdata = 8'h00;
      for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);

      //          rst v  e  d       we re dn hd leds   err
      tbl[0]  = '{1, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00};
      tbl[1]  = '{0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h01, 8'h00};
      tbl[2]  = '{0, 1, 0, 8'h57,  0, 0, 0, 0, 8'h01, 8'h00};
      tbl[3]  = '{0, 1, 0, 8'h10,  0, 0, 0, 0, 8'h01, 8'h00};
      tbl[4]  = '{0, 1, 0, 8'hA5,  0, 0, 0, 0, 8'h01, 8'h00};
      tbl[5]  = '{0, 0, 0, 8'h00,  1, 0, 1, 0, 8'h01, 8'h00};
      tbl[6]  = '{0, 1, 0, 8'h52,  0, 0, 0, 0, 8'h01, 8'h00};
      tbl[7]  = '{0, 1, 0, 8'h10,  0, 0, 0, 0, 8'h01, 8'h00};
      tbl[8]  = '{0, 0, 0, 8'h00,  0, 1, 0, 1, 8'h01, 8'h00};
      tbl[9]  = '{0, 0, 0, 8'h00,  0, 0, 1, 1, 8'h01, 8'h00};
      tbl[10] = '{0, 0, 0, 8'h00,  0, 0, 0, 0, 8'hA5, 8'h00};
      tbl[11] = '{0, 1, 0, 8'h4C,  0, 0, 0, 0, 8'hA5, 8'h00};
      tbl[12] = '{0, 1, 0, 8'h3C,  0, 0, 0, 0, 8'hA5, 8'h00};
      tbl[13] = '{0, 0, 0, 8'h00,  0, 0, 1, 0, 8'h3C, 8'h00};
      tbl[14] = '{0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h3C, 8'h00};

      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].rst, tbl[i].v, tbl[i].e, tbl[i].d);
         if (!tbl[i].rst) begin
            chk("tbl_we", 8'(s_we), 8'(tbl[i].we));
            chk("tbl_re", 8'(s_re), 8'(tbl[i].re));
            chk("tbl_done", 8'(s_done), 8'(tbl[i].done));
            chk("tbl_hold", 8'(s_hold), 8'(tbl[i].hold));
            chk("tbl_leds", s_leds, tbl[i].leds);
            chk("tbl_err", s_err, tbl[i].err);
         end
      end

      // Framing error arriving together with a byte in the middle of a write
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      send(8'h57); send(8'h20);
      cyc(1'b0, 1'b1, 1'b1, 8'h55);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("frm_no_we", 8'(s_we), 8'h00);
      end
      chk("frm_err", s_err, 8'h01);
      send(8'h4C); send(8'hFF); idle(1);
      chk("frm_leds", s_leds, 8'hFF);

      // Inter-byte timeout, checked one cycle before and at expiry
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      send(8'h57);
      idle(99);
      idle(1);
      chk("tmo_before", s_err, 8'h00);
      idle(1);
      chk("tmo_after", s_err, 8'h01);
      send(8'h33); idle(1);
      chk("tmo_stray", s_err, 8'h02);

      // Byte offered while a read is in flight
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      send(8'h52); send(8'h05);
      send(8'h4C);
      chk("hold_issue", 8'(s_hold), 8'h01);
      chk("hold_re", 8'(s_re), 8'h01);
      idle(1);
      chk("hold_err", s_err, 8'h01);
      chk("hold_done", 8'(s_done), 8'h01);
      idle(1);
      chk("hold_leds", s_leds, init_val(5));
      chk("hold_release", 8'(s_hold), 8'h00);
      send(8'h4C); send(8'h77); idle(1);
      chk("hold_idle", s_leds, 8'h77);
      chk("hold_err2", s_err, 8'h01);

      // err_count saturation, then reset straight after a write data byte
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 300; i++) send(8'h00);
      idle(1);
      chk("sat_err", s_err, 8'hFF);
      send(8'h57); send(8'h01); send(8'h02);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("rst_no_we", 8'(s_we), 8'h00);
      idle(1);
      chk("rst_we_after", 8'(s_we), 8'h00);
      chk("rst_err", s_err, 8'h00);
      chk("rst_leds", s_leds, 8'h01);

      // Random traffic
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4000; i++) begin
         logic       v, e;
         logic [7:0] d;
         int         sel;
         if ($urandom_range(0, 299) == 0) begin
            idle(TMO + 5);
         end else begin
            v = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 39) == 0);
            sel = $urandom_range(0, 5);
            case (sel)
               0:       d = 8'h57;
               1:       d = 8'h52;
               2:       d = 8'h4C;
               3:       d = 8'($urandom_range(0, 255));
               default: d = 8'($urandom_range(0, 15));
            endcase
            cyc(1'b0, v, e, d);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
